prog_loader: RTL and testbench

- Byte-stream program loader that writes instruction words into the program memory.
- Receives a framed image from a host-side byte interface: 16-bit word count, data words, XOR checksum.
- Assembles bytes into D_BITS-wide instructions and drives the memory write port from address 0 upward.
- Holds the CPU halted while loading, and after a checksum failure.

---
 rtl/prog_loader.sv | 178 +++++++++++++++++
 tb/tb_prog_loader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader.
// Frame format: word count N (16 bits, MSB first), N instruction words
// (BPW bytes each, MSB first), one XOR checksum byte over the data bytes.
// Words are written to program memory from address 0 upward while the CPU
// is held in halt; the halt is released only after a good checksum.
//
// Handshake: a byte transfers on a rising clk edge where in_valid and
// in_ready are both 1. in_ready depends only on the current state, never on
// in_valid. A byte offered while in_ready is 0 stays with the sender.
module prog_loader #(
    parameter int A_BITS = 10,
    parameter int D_BITS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [A_BITS-1:0] mem_addr,
    output logic [D_BITS-1:0] mem_wdata,
    output logic              cpu_halt,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int BPW  = D_BITS / 8;
    localparam int BC_W = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [A_BITS:0]     widx_q, widx_d;      // one extra bit so N = 2^A_BITS fits
    logic [BC_W-1:0]     bcnt_q, bcnt_d;
    logic [D_BITS-1:0]   shift_q, shift_d;
    logic [7:0]          csum_q, csum_d;
    logic                we_q, we_d;
    logic [A_BITS-1:0]   addr_q, addr_d;
    logic [D_BITS-1:0]   wdata_q, wdata_d;

    logic                xfer;
    logic [15:0]         len_full;
    logic [D_BITS+7:0]   shift_ext;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: length, counters, shift/checksum and write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q   <= '0;
            widx_q  <= '0;
            bcnt_q  <= '0;
            shift_q <= '0;
            csum_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            len_q   <= len_d;
            widx_q  <= widx_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            csum_q  <= csum_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next state and datapath updates on accepted bytes
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        widx_d    = widx_q;
        bcnt_d    = bcnt_q;
        shift_d   = shift_q;
        csum_d    = csum_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        xfer      = in_valid & in_ready;
        len_full  = {len_q[15:8], in_data};
        shift_ext = {shift_q, in_data};

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN_HI;
                    widx_d  = '0;
                    bcnt_d  = '0;
                    csum_d  = '0;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_d   = {in_data, 8'h00};
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d = len_full;
                    if ({16'd0, len_full} > (32'd1 << A_BITS)) begin
                        state_d = S_ERR;
                    end else if (len_full == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    shift_d = shift_ext[D_BITS-1:0];
                    csum_d  = csum_q ^ in_data;
                    if (32'(bcnt_q) == BPW - 1) begin
                        // Word complete: hand it to the write register so the
                        // shift register can take the next byte immediately.
                        we_d    = 1'b1;
                        addr_d  = widx_q[A_BITS-1:0];
                        wdata_d = shift_ext[D_BITS-1:0];
                        bcnt_d  = '0;
                        widx_d  = widx_q + 1'b1;
                        if (32'(widx_q) + 32'd1 == {16'd0, len_q}) begin
                            state_d = S_CSUM;
                        end
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    state_d = (in_data == csum_q) ? S_DONE : S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state and the write register
    always_comb begin
        in_ready  = 1'b0;
        cpu_halt  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        unique case (state_q)
            S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM: begin
                in_ready = 1'b1;
                cpu_halt = 1'b1;
                busy     = 1'b1;
            end
            S_DONE: done = 1'b1;
            S_ERR: begin
                err      = 1'b1;
                cpu_halt = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: drives framed byte streams, predicts memory writes
// into a scoreboard queue and checks status flags after each frame.
module tb_prog_loader;

    localparam int A_BITS = 10;
    localparam int D_BITS = 16;
    localparam int W      = A_BITS + D_BITS;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              mem_we;
    logic [A_BITS-1:0] mem_addr;
    logic [D_BITS-1:0] mem_wdata;
    logic              cpu_halt;
    logic              busy;
    logic              done;
    logic              err;

    int                n_cmp = 0;
    int                n_bad = 0;
    logic [W-1:0]      exp_q[$];
    logic [7:0]        frame_q[$];
    logic [15:0]       words_q[$];
    logic [W-1:0]      mon_e;

    prog_loader #(.A_BITS(A_BITS), .D_BITS(D_BITS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_halt(cpu_halt),
        .busy(busy), .done(done), .err(err)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every write strobe pops one expected {addr,data}
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_we", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("mem_addr", 32'(mem_addr), 32'(mon_e[W-1:D_BITS]));
                check("mem_wdata", 32'(mem_wdata), 32'(mon_e[D_BITS-1:0]));
            end
        end
        if (done === 1'b1 && err === 1'b1) check("done_err_excl", 32'd1, 32'd0);
    end

    // driver tasks (all called at a falling edge)
    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // builds frame_q from words_q and pushes expected writes
    task automatic build_frame(input logic bad_csum);
        logic [7:0] cs = 8'h00;
        frame_q.delete();
        frame_q.push_back(8'(words_q.size() >> 8));
        frame_q.push_back(8'(words_q.size()));
        for (int i = 0; i < words_q.size(); i++) begin
            frame_q.push_back(words_q[i][15:8]);
            frame_q.push_back(words_q[i][7:0]);
            cs = cs ^ words_q[i][15:8] ^ words_q[i][7:0];
            exp_q.push_back({A_BITS'(i), words_q[i]});
        end
        frame_q.push_back(bad_csum ? (cs ^ 8'h01) : cs);
    endtask

    task automatic send_frame(input int gap, input int mid_start_at);
        for (int i = 0; i < frame_q.size(); i++) begin
            send_byte(frame_q[i], gap);
            if (i == mid_start_at) do_start();
        end
    endtask

    // expected {in_ready, cpu_halt, busy, done, err}
    task automatic check_status(input string tag, input logic h, input logic b,
                                input logic d, input logic e);
        check({tag, "_status"}, 32'({in_ready, cpu_halt, busy, done, err}),
              32'({1'b0, h, b, d, e}));
    endtask

    function automatic logic [31:0] all_outs();
        return {in_ready, mem_we, mem_addr, mem_wdata, cpu_halt, busy, done, err};
    endfunction

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        check("reset_outputs", all_outs(), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outputs", all_outs(), 32'd0);

        // 1: two words, good checksum (stream 00 02 12 34 AB CD 40)
        words_q = '{16'h1234, 16'hABCD};
        build_frame(1'b0);
        check("s1_csum_byte", 32'(frame_q[6]), 32'h40);
        do_start();
        check("s1_busy_after_start", 32'({busy, cpu_halt, in_ready}), 32'h7);
        send_frame(0, -1);
        check_status("s1", 1'b0, 1'b0, 1'b1, 1'b0);

        // 2: bad checksum 41, then a byte offered while not ready, then reload
        build_frame(1'b1);
        do_start();
        send_frame(0, -1);
        check_status("s2_bad", 1'b1, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        check_status("s2_hold", 1'b1, 1'b0, 1'b0, 1'b1);
        build_frame(1'b0);
        do_start();
        send_frame(0, -1);
        check_status("s2_good", 1'b0, 1'b0, 1'b1, 1'b0);

        // 3: empty image (00 00 00)
        words_q.delete();
        build_frame(1'b0);
        do_start();
        send_frame(0, -1);
        check_status("s3", 1'b0, 1'b0, 1'b1, 1'b0);

        // 4: length 0x0401 exceeds memory
        frame_q = '{8'h04, 8'h01};
        do_start();
        send_frame(0, -1);
        check_status("s4", 1'b1, 1'b0, 1'b0, 1'b1);

        // boundary: N = 2^A_BITS random words, last write at 2^A_BITS-1
        words_q.delete();
        for (int i = 0; i < (1 << A_BITS); i++) words_q.push_back(16'($urandom_range(0, 65535)));
        build_frame(1'b0);
        do_start();
        send_frame(0, -1);
        check_status("full_mem", 1'b0, 1'b0, 1'b1, 1'b0);

        // 5: gaps between bytes and a start pulse mid-frame
        words_q = '{16'h1234, 16'hABCD};
        build_frame(1'b0);
        do_start();
        send_frame(3, 3);
        check_status("s5", 1'b0, 1'b0, 1'b1, 1'b0);

        // 6: asynchronous reset after the first data byte, then a full reload
        do_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        #2 rst_n = 1'b0;
        #1 check("s6_async_reset", all_outs(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("s6_after_reset", all_outs(), 32'd0);
        build_frame(1'b0);
        do_start();
        send_frame(0, -1);
        check_status("s6", 1'b0, 1'b0, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        check("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
